// File: rtl/hub75_bcm_driver.sv
// HUB-75 dual-half panel scanner with BCM colour depth, fed from a synchronous framebuffer.
// Latency: colour bit for {y,x} reaches the pins 2 cycles after its address; free-running, no backpressure.
module hub75_bcm_driver #(
    parameter int k_width      = 64,
    parameter int k_scan_rows  = 32,
    parameter int k_color_bits = 4,
    parameter int k_oe_base    = 8,
    parameter int k_blank      = 2
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic                                              enable,
    output logic [$clog2(k_scan_rows)+$clog2(k_width)-1:0]    fb_addr,
    input  logic [6*k_color_bits-1:0]                         fb_data,
    output logic                                              r1,
    output logic                                              g1,
    output logic                                              b1,
    output logic                                              r2,
    output logic                                              g2,
    output logic                                              b2,
    output logic [$clog2(k_scan_rows)-1:0]                    abcde,
    output logic                                              clk,
    output logic                                              lat,
    output logic                                              oe,
    output logic                                              frame_start
);

    localparam int k_xw        = $clog2(k_width);
    localparam int k_yw        = $clog2(k_scan_rows);
    localparam int k_pw        = (k_color_bits > 1) ? $clog2(k_color_bits) : 1;
    localparam int k_shift_len = 2 * k_width;
    localparam int k_disp_max  = k_oe_base << (k_color_bits - 1);
    localparam int k_cnt_max0  = (k_shift_len > k_blank) ? k_shift_len : k_blank;
    localparam int k_cnt_max   = (k_cnt_max0 > k_disp_max) ? k_cnt_max0 : k_disp_max;
    localparam int k_cw        = $clog2(k_cnt_max + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_BLANK,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t                 state_q, state_d;
    logic [k_cw-1:0]        cnt_q, cnt_d;
    logic [k_yw-1:0]        y_q, y_d;
    logic [k_pw-1:0]        p_q, p_d;

    logic [k_yw+k_xw-1:0]   fb_addr_q, fb_addr_d;
    // Colour bits packed as {r1,g1,b1,r2,g2,b2}
    logic [5:0]             rgb_q, rgb_d;
    logic [k_yw-1:0]        abcde_q, abcde_d;
    logic                   clk_q, clk_d;
    logic                   lat_q, lat_d;
    logic                   oe_q, oe_d;
    logic                   frame_start_q, frame_start_d;

    logic [k_cw-1:0]        disp_len;
    logic [k_xw-1:0]        shift_x;
    logic [5:0]             plane_bits;

    assign disp_len = k_cw'(k_oe_base) << p_q;

    // Next scan position: counters advance first, outputs are then derived from the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + k_cw'(1);
        y_d     = y_q;
        p_d     = p_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (enable) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (cnt_q == k_cw'(1)) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (cnt_q == k_cw'(k_shift_len - 1)) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                end
            end
            S_BLANK: begin
                if (cnt_q == k_cw'(k_blank - 1)) begin
                    state_d = S_LATCH;
                    cnt_d   = '0;
                end
            end
            S_LATCH: begin
                state_d = S_DISPLAY;
                cnt_d   = '0;
            end
            S_DISPLAY: begin
                if (cnt_q == disp_len - k_cw'(1)) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    if (p_q != k_pw'(k_color_bits - 1)) begin
                        p_d = p_q + k_pw'(1);
                    end else if (y_q != k_yw'(k_scan_rows - 1)) begin
                        p_d = '0;
                        y_d = y_q + k_yw'(1);
                    end else begin
                        p_d = '0;
                        y_d = '0;
                        if (!enable) state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Field i of fb_data: 0=b1 1=g1 2=r1 3=b2 4=g2 5=r2; reorder to {r1,g1,b1,r2,g2,b2}
    always_comb begin
        plane_bits    = '0;
        plane_bits[0] = fb_data[3*k_color_bits + int'(p_q)];
        plane_bits[1] = fb_data[4*k_color_bits + int'(p_q)];
        plane_bits[2] = fb_data[5*k_color_bits + int'(p_q)];
        plane_bits[3] = fb_data[0*k_color_bits + int'(p_q)];
        plane_bits[4] = fb_data[1*k_color_bits + int'(p_q)];
        plane_bits[5] = fb_data[2*k_color_bits + int'(p_q)];
    end

    always_comb begin
        shift_x       = cnt_d[k_xw:1];
        fb_addr_d     = fb_addr_q;
        rgb_d         = rgb_q;
        abcde_d       = abcde_q;
        clk_d         = (state_d == S_SHIFT) && cnt_d[0];
        lat_d         = (state_d == S_LATCH);
        oe_d          = (state_d != S_DISPLAY);
        frame_start_d = (state_d == S_FETCH) && (cnt_d == '0) && (y_d == '0) && (p_d == '0)
                        && !((state_q == S_FETCH) && (cnt_q == '0));
        case (state_d)
            S_IDLE: begin
                fb_addr_d = '0;
                rgb_d     = '0;
                abcde_d   = '0;
            end
            S_FETCH: begin
                if (cnt_d == '0) fb_addr_d = {y_d, {k_xw{1'b0}}};
            end
            S_SHIFT: begin
                // Phase 0: capture the word requested one cycle ago and request the next column
                if (!cnt_d[0]) begin
                    rgb_d = plane_bits;
                    if (shift_x != {k_xw{1'b1}}) fb_addr_d = {y_d, shift_x + k_xw'(1)};
                end
            end
            S_LATCH: begin
                abcde_d = y_d;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            y_q           <= '0;
            p_q           <= '0;
            fb_addr_q     <= '0;
            rgb_q         <= '0;
            abcde_q       <= '0;
            clk_q         <= 1'b0;
            lat_q         <= 1'b0;
            oe_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            y_q           <= y_d;
            p_q           <= p_d;
            fb_addr_q     <= fb_addr_d;
            rgb_q         <= rgb_d;
            abcde_q       <= abcde_d;
            clk_q         <= clk_d;
            lat_q         <= lat_d;
            oe_q          <= oe_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign fb_addr     = fb_addr_q;
    assign r1          = rgb_q[5];
    assign g1          = rgb_q[4];
    assign b1          = rgb_q[3];
    assign r2          = rgb_q[2];
    assign g2          = rgb_q[1];
    assign b2          = rgb_q[0];
    assign abcde       = abcde_q;
    assign clk         = clk_q;
    assign lat         = lat_q;
    assign oe          = oe_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench for hub75_bcm_driver in the 4x2, 2-bit configuration (35 cycles/row, 70/frame).
// Framebuffer is a one-cycle synchronous read model; outputs are sampled 1 time unit after each edge.
module tb_hub75_bcm_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  fb_addr;
    logic [11:0] fb_data;
    logic        r1, g1, b1, r2, g2, b2;
    logic [0:0]  abcde;
    logic        clk, lat, oe, frame_start;

    hub75_bcm_driver #(
        .k_width      (4),
        .k_scan_rows  (2),
        .k_color_bits (2),
        .k_oe_base    (3),
        .k_blank      (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .r1          (r1),
        .g1          (g1),
        .b1          (b1),
        .r2          (r2),
        .g2          (g2),
        .b2          (b2),
        .abcde       (abcde),
        .clk         (clk),
        .lat         (lat),
        .oe          (oe),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    // Framebuffer words {r2,g2,b2,r1,g1,b1}, 2 bits per field
    logic [11:0] mem [8];
    logic        fixed_mode;
    always @(posedge clock) fb_data <= fixed_mode ? 12'b101101_011010 : mem[fb_addr];

    // Observation word: [13]oe [12]lat [11]clk [10]frame_start [9]abcde [8:6]fb_addr [5:0]{r1,g1,b1,r2,g2,b2}
    logic [13:0] obs;
    assign obs = {oe, lat, clk, frame_start, abcde, fb_addr, r1, g1, b1, r2, g2, b2};
    localparam logic [13:0] k_idle = 14'h2000;

    logic [13:0] rec [256];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic record(input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) enable = 1'b0;
            rec[i] = obs;
            tick();
        end
    endtask

    function automatic logic [127:0] col(input int bitpos, input int from, input int n);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[k] = rec[from + k][bitpos];
        return v;
    endfunction

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [2:0]   exp_addr [10];
    logic [5:0]   exp_col  [10];
    logic [127:0] oe_mask;
    int           fs_cnt;

    initial begin
        mem[0] = 12'b00_01_10_11_00_01;
        mem[1] = 12'b11_10_01_00_11_10;
        mem[2] = 12'b01_01_00_01_00_00;
        mem[3] = 12'b00_00_11_10_11_01;
        mem[4] = 12'hFFF;
        mem[5] = 12'h000;
        mem[6] = 12'h000;
        mem[7] = 12'h000;
        fixed_mode = 1'b0;
        exp_addr = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
        exp_col  = '{6'b101010, 6'b101010, 6'b010101, 6'b010101, 6'b100110,
                     6'b100110, 6'b011001, 6'b011001, 6'b011001, 6'b011001};

        // Reset and idle hold
        do_reset();
        chk("reset_vals", 128'(obs), 128'(k_idle));
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_hold", 128'(obs), 128'(k_idle));
        end

        // One frame from a single-cycle enable pulse
        enable = 1'b1;
        tick();
        record(80, 0);
        chk("fs_once", col(10, 0, 80), 128'h1);
        chk("clk_pat", col(11, 0, 10), 128'h2A8);
        for (int i = 0; i < 10; i++) chk("fb_addr_seq", 128'(rec[i][8:6]), 128'(exp_addr[i]));
        for (int i = 0; i < 10; i++) chk("plane0_col", 128'(rec[i + 2][5:0]), 128'(exp_col[i]));
        chk("plane1_col", 128'(rec[18][5:0]), 128'(6'b100001));
        chk("row1_addr", 128'(rec[35][8:6]), 128'd4);
        chk("row1_col", 128'(rec[37][5:0]), 128'(6'b111111));
        chk("lat_frame", col(12, 0, 70),
            (128'd1 << 12) | (128'd1 << 28) | (128'd1 << 47) | (128'd1 << 63));
        oe_mask = (128'h7 << 13) | (128'h3F << 29) | (128'h7 << 48) | (128'h3F << 64);
        chk("oe_bcm", col(13, 0, 70), ~oe_mask & ((128'd1 << 70) - 128'd1));
        chk("abcde_row0", 128'(rec[46][9]), 128'd0);
        chk("abcde_row1", 128'(rec[47][9]), 128'd1);
        chk("abcde_hold", 128'(rec[69][9]), 128'd1);
        chk("idle_after", 128'(rec[72]), 128'(k_idle));
        chk("idle_later", 128'(rec[79]), 128'(k_idle));

        // Bit ordering with a fixed word
        do_reset();
        fixed_mode = 1'b1;
        enable = 1'b1;
        tick();
        record(20, 0);
        chk("bitord_p0", 128'(rec[2][5:0]), 128'(6'b100011));
        chk("bitord_p1", 128'(rec[18][5:0]), 128'(6'b011110));
        fixed_mode = 1'b0;

        // Back-to-back frames, enable dropped in the middle of the third
        do_reset();
        enable = 1'b1;
        tick();
        record(220, 170);
        fs_cnt = 0;
        for (int i = 0; i < 220; i++) if (rec[i][10]) fs_cnt++;
        chk("fs_count", 128'(fs_cnt), 128'd3);
        chk("fs_at_70", 128'(rec[70][10]), 128'd1);
        chk("fs_at_140", 128'(rec[140][10]), 128'd1);
        chk("lat_f3", 128'(rec[203][12]), 128'd1);
        chk("oe_last", 128'(rec[209][13]), 128'd0);
        chk("idle_f3", 128'(rec[210]), 128'(k_idle));
        chk("idle_f3b", 128'(rec[219]), 128'(k_idle));

        // Reset in the middle of SHIFT, then restart
        do_reset();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("pre_rst_addr", 128'(fb_addr), 128'd3);
        reset = 1'b1;
        tick();
        chk("rst_mid", 128'(obs), 128'(k_idle));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_idle", 128'(obs), 128'(k_idle));
        enable = 1'b1;
        tick();
        enable = 1'b0;
        chk("restart_fs", 128'({frame_start, fb_addr}), 128'(4'b1000));
        tick();
        tick();
        chk("restart_addr", 128'(fb_addr), 128'd1);
        chk("restart_col", 128'(obs[5:0]), 128'(6'b101010));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
